cernbe_submap_demux: RTL

Parametrised CERN-BE bus address decoder that fans one master port out to `N_SUB` submaps, each occupying an equal power-of-two window. It keeps the write-input and read-output register stages of the single-submap bridge. It adds per-transaction index decode, an unmapped-address error response and a bus-timeout watchdog. It sits between the top-level register map and the submap slave blocks.

---
 rtl/cernbe_submap_demux.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cernbe_submap_demux.sv
// CERN-BE bus decoder: one master port fanned out to N_SUB equal power-of-two submap windows,
// with unmapped-address error response and a bus-timeout watchdog.
module cernbe_submap_demux #(
  parameter int unsigned N_SUB   = 4,
  parameter int unsigned AW      = 12,
  parameter int unsigned SUB_AW  = 10,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  Clk,
  input  logic                  rst_n,
  input  logic [AW-1:2]         VMEAddr,
  input  logic [31:0]           VMEWrData,
  input  logic                  VMERdMem,
  input  logic                  VMEWrMem,
  output logic [31:0]           VMERdData,
  output logic                  VMERdDone,
  output logic                  VMEWrDone,
  output logic                  VMERdError,
  output logic                  VMEWrError,
  output logic [SUB_AW-1:2]     sub_VMEAddr_o,
  output logic [31:0]           sub_VMEWrData_o,
  output logic [N_SUB-1:0]      sub_VMERdMem_o,
  output logic [N_SUB-1:0]      sub_VMEWrMem_o,
  input  logic [N_SUB*32-1:0]   sub_VMERdData_i,
  input  logic [N_SUB-1:0]      sub_VMERdDone_i,
  input  logic [N_SUB-1:0]      sub_VMEWrDone_i
);

  localparam int unsigned IW = (AW > SUB_AW) ? AW - SUB_AW : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       tx_idx, tx_idx_nx;
  logic                tx_unmapped, tx_unmapped_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [31:0]         rd_data, rd_data_nx;
  logic                rd_done, rd_done_nx;
  logic                wr_done, wr_done_nx;
  logic                rd_err, rd_err_nx;
  logic                wr_err, wr_err_nx;
  logic [SUB_AW-1:2]   sub_addr, sub_addr_nx;
  logic [31:0]         sub_wdata, sub_wdata_nx;
  logic [N_SUB-1:0]    sub_rd, sub_rd_nx;
  logic [N_SUB-1:0]    sub_wr, sub_wr_nx;

  logic [IW-1:0]       req_idx;
  logic                req_mapped;
  logic [N_SUB-1:0]    req_onehot;
  logic                sel_rd_done;
  logic                sel_wr_done;
  logic [31:0]         sel_rd_data;
  logic                timed_out;

  // Window index of the incoming request; a single-window map has no index bits.
  generate
    if (AW > SUB_AW) begin : g_idx
      assign req_idx = VMEAddr[AW-1:SUB_AW];
    end else begin : g_no_idx
      assign req_idx = '0;
    end
  endgenerate

  assign req_mapped = (32'(req_idx) < N_SUB);
  assign req_onehot = N_SUB'(1) << req_idx;
  assign timed_out  = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

  // Observe only the done/data lane of the submap owning the transaction.
  always_comb begin
    sel_rd_done = 1'b0;
    sel_wr_done = 1'b0;
    sel_rd_data = '0;
    for (int k = 0; k < N_SUB; k++) begin
      if (tx_idx == IW'(k)) begin
        sel_rd_done = sub_VMERdDone_i[k];
        sel_wr_done = sub_VMEWrDone_i[k];
        sel_rd_data = sub_VMERdData_i[32*k +: 32];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx       = state;
    tx_idx_nx      = tx_idx;
    tx_unmapped_nx = tx_unmapped;
    cnt_nx         = cnt;
    rd_data_nx     = rd_data;
    rd_done_nx     = 1'b0;
    wr_done_nx     = 1'b0;
    rd_err_nx      = 1'b0;
    wr_err_nx      = 1'b0;
    sub_addr_nx    = sub_addr;
    sub_wdata_nx   = sub_wdata;
    sub_rd_nx      = '0;
    sub_wr_nx      = '0;

    case (state)
      IDLE, RESP: begin
        state_nx = IDLE;
        if (VMEWrMem || VMERdMem) begin
          // Write wins over a simultaneous read; unmapped requests still pass
          // through a wait state so their error Done lands in the same cycle as a zero-wait slave.
          tx_idx_nx      = req_idx;
          tx_unmapped_nx = !req_mapped;
          cnt_nx         = '0;
          state_nx       = VMEWrMem ? WR_WAIT : RD_WAIT;
          if (req_mapped) begin
            sub_addr_nx = VMEAddr[SUB_AW-1:2];
            if (VMEWrMem) begin
              sub_wdata_nx = VMEWrData;
              sub_wr_nx    = req_onehot;
            end else begin
              sub_rd_nx = req_onehot;
            end
          end
        end
      end

      RD_WAIT: begin
        if (tx_unmapped) begin
          rd_done_nx = 1'b1;
          rd_err_nx  = 1'b1;
          rd_data_nx = '0;
          state_nx   = RESP;
        end else if (sel_rd_done) begin
          rd_done_nx = 1'b1;
          rd_data_nx = sel_rd_data;
          state_nx   = RESP;
        end else if (timed_out) begin
          rd_done_nx = 1'b1;
          rd_err_nx  = 1'b1;
          rd_data_nx = '0;
          state_nx   = RESP;
        end else if (cnt != CW'(TIMEOUT)) begin
          cnt_nx = cnt + CW'(1);
        end
      end

      WR_WAIT: begin
        if (tx_unmapped) begin
          wr_done_nx = 1'b1;
          wr_err_nx  = 1'b1;
          state_nx   = RESP;
        end else if (sel_wr_done) begin
          wr_done_nx = 1'b1;
          state_nx   = RESP;
        end else if (timed_out) begin
          wr_done_nx = 1'b1;
          wr_err_nx  = 1'b1;
          state_nx   = RESP;
        end else if (cnt != CW'(TIMEOUT)) begin
          cnt_nx = cnt + CW'(1);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_idx      <= '0;
      tx_unmapped <= 1'b0;
      cnt         <= '0;
      rd_data     <= '0;
      rd_done     <= 1'b0;
      wr_done     <= 1'b0;
      rd_err      <= 1'b0;
      wr_err      <= 1'b0;
      sub_addr    <= '0;
      sub_wdata   <= '0;
      sub_rd      <= '0;
      sub_wr      <= '0;
    end else begin
      state       <= state_nx;
      tx_idx      <= tx_idx_nx;
      tx_unmapped <= tx_unmapped_nx;
      cnt         <= cnt_nx;
      rd_data     <= rd_data_nx;
      rd_done     <= rd_done_nx;
      wr_done     <= wr_done_nx;
      rd_err      <= rd_err_nx;
      wr_err      <= wr_err_nx;
      sub_addr    <= sub_addr_nx;
      sub_wdata   <= sub_wdata_nx;
      sub_rd      <= sub_rd_nx;
      sub_wr      <= sub_wr_nx;
    end
  end

  assign VMERdData       = rd_data;
  assign VMERdDone       = rd_done;
  assign VMEWrDone       = wr_done;
  assign VMERdError      = rd_err;
  assign VMEWrError      = wr_err;
  assign sub_VMEAddr_o   = sub_addr;
  assign sub_VMEWrData_o = sub_wdata;
  assign sub_VMERdMem_o  = sub_rd;
  assign sub_VMEWrMem_o  = sub_wr;

endmodule
